// File: rtl/usb_tx_fifo_buf.sv
// usb_tx_fifo_buf: single-clock, byte-wide TX data FIFO for the USB slave
// endpoint path. The bus interface writes bytes in; the packet transmitter
// reads them out through a registered data port.
//
// Optional feature: define USB_TXFIFO_ERRFLAGS_EN to add the sticky
// overflow/underflow ports. With the macro undefined those ports and their
// logic are absent and everything else behaves the same.
module usb_tx_fifo_buf #(
    parameter int FIFO_DEPTH = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic        busClk,
    input  logic        rst_n,
    input  logic        fifoWEn,
    input  logic [7:0]  busDataIn,
    input  logic        forceEmpty,
    input  logic        fifoREn,
    output logic [7:0]  dataOut,
    output logic        fifoEmpty,
    output logic        fifoFull,
    output logic [15:0] numElementsInFifo
`ifdef USB_TXFIFO_ERRFLAGS_EN
    ,
    output logic        overflow,
    output logic        underflow
`endif
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [7:0]            mem_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [7:0]            dout_q, dout_d;
    logic                  wr_ok;
    logic                  rd_ok;

    // Status decodes straight from the registered count, so they are
    // glitch-free and reflect an edge's operation right after that edge.
    assign fifoEmpty         = (count_q == '0);
    assign fifoFull          = (count_q == FULL_CNT);
    assign numElementsInFifo = 16'(count_q);
    assign dataOut           = dout_q;

    // Full/empty are evaluated pre-edge, so a write while full is dropped
    // even if a read frees a slot on the same edge.
    assign wr_ok = fifoWEn & ~fifoFull;
    assign rd_ok = fifoREn & ~fifoEmpty;

    // Next-state logic for pointers, occupancy and read data; flush wins.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        dout_d  = dout_q;
        if (forceEmpty) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (wr_ok) begin
                wptr_d = wptr_q + ADDR_WIDTH'(1);
            end
            if (rd_ok) begin
                rptr_d = rptr_q + ADDR_WIDTH'(1);
                dout_d = mem_q[rptr_q];
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer, count and output-data registers.
    always_ff @(posedge busClk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            dout_q  <= 8'h00;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            dout_q  <= dout_d;
        end
    end

    // Byte storage: written on accepted writes that are not being flushed.
    // NOTE: the array has no reset; its contents are unreachable until
    // written because the pointers and count are reset, and leaving it out
    // lets the array map onto plain storage.
    always_ff @(posedge busClk) begin
        if (wr_ok && !forceEmpty) begin
            mem_q[wptr_q] <= busDataIn;
        end
    end

`ifdef USB_TXFIFO_ERRFLAGS_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    assign overflow  = ovf_q;
    assign underflow = unf_q;

    // Sticky error flags; a flush clears them even with a coincident error.
    always_comb begin
        ovf_d = ovf_q | (fifoWEn & fifoFull);
        unf_d = unf_q | (fifoREn & fifoEmpty);
        if (forceEmpty) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
    end

    // Error flag registers.
    always_ff @(posedge busClk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end
`endif

endmodule

// File: tb/tb_usb_tx_fifo_buf.sv
// Self-checking bench for usb_tx_fifo_buf: directed scenarios followed by a
// random phase, all compared against a queue-based reference model.
module tb_usb_tx_fifo_buf;

    localparam int DEPTH = 64;

    logic        busClk;
    logic        rst_n;
    logic        fifoWEn;
    logic [7:0]  busDataIn;
    logic        forceEmpty;
    logic        fifoREn;
    logic [7:0]  dataOut;
    logic        fifoEmpty;
    logic        fifoFull;
    logic [15:0] numElementsInFifo;
`ifdef USB_TXFIFO_ERRFLAGS_EN
    logic        overflow;
    logic        underflow;
`endif

    usb_tx_fifo_buf #(.FIFO_DEPTH(DEPTH), .ADDR_WIDTH(6)) dut (
        .busClk            (busClk),
        .rst_n             (rst_n),
        .fifoWEn           (fifoWEn),
        .busDataIn         (busDataIn),
        .forceEmpty        (forceEmpty),
        .fifoREn           (fifoREn),
        .dataOut           (dataOut),
        .fifoEmpty         (fifoEmpty),
        .fifoFull          (fifoFull),
        .numElementsInFifo (numElementsInFifo)
`ifdef USB_TXFIFO_ERRFLAGS_EN
        ,
        .overflow          (overflow),
        .underflow         (underflow)
`endif
    );

    initial busClk = 1'b0;
    always #5 busClk = ~busClk;

    // Reference model state
    logic [7:0] m_q[$];
    logic [7:0] m_dout;
    logic       m_ovf;
    logic       m_unf;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".dataOut"}, 16'(dataOut), 16'(m_dout));
        check({tag, ".empty"},   16'(fifoEmpty), 16'(m_q.size() == 0));
        check({tag, ".full"},    16'(fifoFull), 16'(m_q.size() == DEPTH));
        check({tag, ".count"},   numElementsInFifo, 16'(m_q.size()));
`ifdef USB_TXFIFO_ERRFLAGS_EN
        check({tag, ".overflow"},  16'(overflow), 16'(m_ovf));
        check({tag, ".underflow"}, 16'(underflow), 16'(m_unf));
`endif
    endtask

    task automatic model_reset();
        m_q.delete();
        m_dout = 8'h00;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    // One clock edge of FIFO behaviour, using the pre-edge occupancy.
    task automatic model_edge(input logic we, input logic [7:0] din, input logic re, input logic fe);
        bit full;
        bit empty;
        full  = (m_q.size() == DEPTH);
        empty = (m_q.size() == 0);
        if (fe) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (we && full)  m_ovf = 1'b1;
            if (re && empty) m_unf = 1'b1;
            if (re && !empty) m_dout = m_q.pop_front();
            if (we && !full)  m_q.push_back(din);
        end
    endtask

    // Drive inputs, take one edge, then compare 1 time unit after the edge.
    task automatic cycle(input string tag, input logic we, input logic [7:0] din,
                         input logic re, input logic fe);
        fifoWEn    = we;
        busDataIn  = din;
        fifoREn    = re;
        forceEmpty = fe;
        @(posedge busClk);
        model_edge(we, din, re, fe);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n      = 1'b1;
        fifoWEn    = 1'b0;
        busDataIn  = 8'h00;
        forceEmpty = 1'b0;
        fifoREn    = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        #1 check_all("reset");
        #10 rst_n = 1'b1;

        // Three bytes in, three bytes out in order
        cycle("wr_a1", 1'b1, 8'hA1, 1'b0, 1'b0);
        cycle("wr_b2", 1'b1, 8'hB2, 1'b0, 1'b0);
        cycle("wr_c3", 1'b1, 8'hC3, 1'b0, 1'b0);
        check("three_count", numElementsInFifo, 16'd3);
        cycle("rd_a1", 1'b0, 8'h00, 1'b1, 1'b0);
        check("rd_a1_val", 16'(dataOut), 16'h00A1);
        cycle("rd_b2", 1'b0, 8'h00, 1'b1, 1'b0);
        check("rd_b2_val", 16'(dataOut), 16'h00B2);
        cycle("rd_c3", 1'b0, 8'h00, 1'b1, 1'b0);
        check("rd_c3_val", 16'(dataOut), 16'h00C3);
        check("three_empty", 16'(fifoEmpty), 16'd1);
        cycle("idle_hold", 1'b0, 8'h00, 1'b0, 1'b0);

        // Fill to full, overflow attempt, drain
        for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, 8'(i), 1'b0, 1'b0);
        check("fill_full", 16'(fifoFull), 16'd1);
        check("fill_count", numElementsInFifo, 16'd64);
        cycle("ovf_wr", 1'b1, 8'hFF, 1'b0, 1'b0);
        check("ovf_count", numElementsInFifo, 16'd64);
        for (int i = 0; i < DEPTH; i++) begin
            cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);
            check("drain_seq", 16'(dataOut), 16'(i));
        end
        cycle("drain_empty_rd", 1'b0, 8'h00, 1'b1, 1'b0);
        check("no_ff", 16'(dataOut), 16'd63);

        // Simultaneous read/write at count 10
        for (int i = 0; i < 10; i++) cycle("pre10", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle("rw10", 1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
            check("rw10_data", 16'(dataOut), 16'(8'h40 + i));
            check("rw10_count", numElementsInFifo, 16'd10);
        end
        // Top up to full, then read+write on the same edge
        while (m_q.size() < DEPTH) cycle("topup", 1'b1, 8'($urandom), 1'b0, 1'b0);
        cycle("rw_full", 1'b1, 8'hEE, 1'b1, 1'b0);
        check("rw_full_count", numElementsInFifo, 16'd63);
        check("rw_full_data", 16'(dataOut), 16'h0045);
        cycle("flush1", 1'b0, 8'h00, 1'b0, 1'b1);

        // 100 write/read pairs wrap the pointers
        for (int i = 0; i < 100; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            cycle("wrap_wr", 1'b1, b, 1'b0, 1'b0);
            cycle("wrap_rd", 1'b0, 8'h00, 1'b1, 1'b0);
            check("wrap_data", 16'(dataOut), 16'(b));
        end

        // Flush with a coincident write at count 20
        for (int i = 0; i < 20; i++) cycle("pre20", 1'b1, 8'($urandom), 1'b0, 1'b0);
        cycle("flush_wr", 1'b1, 8'h77, 1'b0, 1'b1);
        check("flush_count", numElementsInFifo, 16'd0);
        check("flush_empty", 16'(fifoEmpty), 16'd1);
        cycle("wr_5a", 1'b1, 8'h5A, 1'b0, 1'b0);
        cycle("rd_5a", 1'b0, 8'h00, 1'b1, 1'b0);
        check("rd_5a_val", 16'(dataOut), 16'h005A);

        // Asynchronous reset mid-burst at count 7
        for (int i = 0; i < 7; i++) cycle("pre7", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        fifoWEn   = 1'b1;
        busDataIn = 8'h99;
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all("async_rst");
        check("async_rst_count", numElementsInFifo, 16'd0);
        fifoWEn = 1'b0;
        @(posedge busClk);
        #2 rst_n = 1'b1;
        cycle("rd_after_rst", 1'b0, 8'h00, 1'b1, 1'b0);
        check("rd_after_rst_dout", 16'(dataOut), 16'h0000);

        // Random traffic with occasional flushes
        for (int i = 0; i < 600; i++) begin
            cycle("rand",
                  1'($urandom_range(0, 99) < 60),
                  8'($urandom),
                  1'($urandom_range(0, 99) < 55),
                  1'($urandom_range(0, 49) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Overall watchdog so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
